aes128_encrypt_ctrl: RTL and testbench

Iterative AES-128 encryption controller: sequences the initial AddRoundKey, nine full rounds and the final round over one shared 128-bit state register, one round per clock. It expands the key on the fly and reuses the team's `addroundkey` block for every key mix. It sits between the host-side block loader and the ciphertext sink, accepting one block per start/done transaction.

---
 rtl/aes128_encrypt_ctrl.sv | 152 +++++++++++++++
 tb/tb_aes128_encrypt_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_encrypt_ctrl.sv
// Iterative AES-128 encryption: one round per clock over a shared 128-bit state,
// with the round key expanded on the fly alongside the data path.
module aes128_encrypt_ctrl (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
   output logic         ready,
   output logic         busy,
   output logic         done,
   output logic [127:0] ciphertext,
   output logic [3:0]   round_idx
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

   localparam logic [0:255][7:0] SBOX = {
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[x];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] addroundkey(input logic [127:0] blk, input logic [127:0] rk);
      return blk ^ rk;
   endfunction

   fsm_t         state_q, state_d;
   logic [127:0] blk_q, blk_d;
   logic [127:0] rk_q, rk_d;
   logic [7:0]   rcon_q, rcon_d;
   logic [3:0]   round_q, round_d;
   logic [127:0] ct_q, ct_d;

   logic [7:0]   sb_bytes [16];
   logic [127:0] sr_blk, mc_blk, round_blk, next_rk, ark_o;
   logic [31:0]  w0, w1, w2, w3, kt, n0, n1, n2, n3;

   // Byte b sits at row b%4, column b/4; ShiftRows pulls row r from column (c+r)%4.
   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_sub
         assign sb_bytes[gi] = sbox(blk_q[127-8*gi -: 8]);
         assign sr_blk[127-8*gi -: 8] = sb_bytes[(gi % 4) + 4 * (((gi / 4) + (gi % 4)) % 4)];
      end
      for (gi = 0; gi < 4; gi++) begin : g_mix
         logic [7:0] a0, a1, a2, a3;
         assign a0 = sr_blk[127-32*gi -: 8];
         assign a1 = sr_blk[119-32*gi -: 8];
         assign a2 = sr_blk[111-32*gi -: 8];
         assign a3 = sr_blk[103-32*gi -: 8];
         assign mc_blk[127-32*gi -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
   endgenerate

   assign {w0, w1, w2, w3} = rk_q;
   assign kt = {sbox(w3[23:16]) ^ rcon_q, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
   assign n0 = w0 ^ kt;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;
   assign next_rk = {n0, n1, n2, n3};

   assign round_blk = (round_q == 4'd10) ? sr_blk : mc_blk;
   // One key mix serves both the initial load and every round.
   assign ark_o = (state_q == S_RUN) ? addroundkey(round_blk, next_rk)
                                     : addroundkey(plaintext, key);

   always_comb begin
      state_d = state_q;
      blk_d   = blk_q;
      rk_d    = rk_q;
      rcon_d  = rcon_q;
      round_d = round_q;
      ct_d    = ct_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               blk_d   = ark_o;
               rk_d    = key;
               rcon_d  = 8'h01;
               round_d = 4'd1;
               state_d = S_RUN;
            end else if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            blk_d  = ark_o;
            rk_d   = next_rk;
            rcon_d = xtime(rcon_q);
            if (round_q == 4'd10) begin
               ct_d    = ark_o;
               round_d = 4'd0;
               state_d = S_DONE;
            end else begin
               round_d = round_q + 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         blk_q   <= '0;
         rk_q    <= '0;
         rcon_q  <= 8'h01;
         round_q <= '0;
         ct_q    <= '0;
      end else begin
         state_q <= state_d;
         blk_q   <= blk_d;
         rk_q    <= rk_d;
         rcon_q  <= rcon_d;
         round_q <= round_d;
         ct_q    <= ct_d;
      end
   end

   assign ready      = (state_q != S_RUN);
   assign busy       = (state_q == S_RUN);
   assign done       = (state_q == S_DONE);
   assign ciphertext = ct_q;
   assign round_idx  = round_q;

endmodule

// File: tb/tb_aes128_encrypt_ctrl.sv
// Bench for aes128_encrypt_ctrl: FIPS-197 vectors, protocol corner cases and
// random blocks checked against a byte-level AES model with a computed S-box.
module tb_aes128_encrypt_ctrl;

   logic         clk, rst, start;
   logic [127:0] plaintext, key;
   logic         ready, busy, done;
   logic [127:0] ciphertext;
   logic [3:0]   round_idx;

   aes128_encrypt_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .plaintext(plaintext), .key(key),
      .ready(ready), .busy(busy), .done(done), .ciphertext(ciphertext), .round_idx(round_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_S0   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, want);
   endtask

   // ---------------- reference model ----------------
   logic [7:0] ref_sbox [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p ^= (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p ^= (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, xb, yb;
      for (int x = 0; x < 256; x++) begin
         xb  = x[7:0];
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            yb = y[7:0];
            if (gmul(xb, yb) == 8'h01) inv = yb;
         end
         ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
      logic [31:0]  w [44];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [31:0]  tmp;
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {ref_sbox[tmp[23:16]] ^ rc, ref_sbox[tmp[15:8]], ref_sbox[tmp[7:0]], ref_sbox[tmp[31:24]]};
            rc  = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int b = 0; b < 16; b++) t[b] = ref_sbox[s[b]];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) s[r+4*c] = t[r+4*((c+r)%4)];
         if (rnd < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         end
         for (int b = 0; b < 16; b++) s[b] ^= w[4*rnd + b/4][31-8*(b%4) -: 8];
      end
      for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
      return res;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Called 1 time unit after a rising edge with the DUT ready; returns 1 unit after
   // the edge that follows DONE. Inputs are scrambled during RUN; poke_round>0 pulses
   // start at that round, which must be ignored.
   task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] k,
                            input logic [127:0] want, input int poke_round);
      plaintext = pt; key = k; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      plaintext = rand128(); key = rand128();
      check_eq({tag, "_busy"},  128'(busy),  128'(1));
      check_eq({tag, "_ready"}, 128'(ready), 128'(0));
      for (int r = 1; r <= 10; r++) begin
         check_eq({tag, "_round"}, 128'(round_idx), 128'(r));
         check_eq({tag, "_nodone"}, 128'(done), 128'(0));
         start = (r == poke_round);
         @(posedge clk); #1;
      end
      start = 1'b0;
      check_eq({tag, "_done"},  128'(done),  128'(1));
      check_eq({tag, "_rdy"},   128'(ready), 128'(1));
      check_eq({tag, "_idle"},  128'(busy),  128'(0));
      check_eq({tag, "_r0"},    128'(round_idx), 128'(0));
      check_eq({tag, "_ct"},    ciphertext, want);
      $display("blk %s pt=%h key=%h ct=%h", tag, pt, k, ciphertext);
      @(posedge clk); #1;
      check_eq({tag, "_pulse"}, 128'(done), 128'(0));
   endtask

   logic [127:0] want, pt_r, key_r;
   bit           seen_done;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; plaintext = '0; key = '0;
      build_sbox();
      repeat (2) @(posedge clk); #1;
      check_eq("rst_ready", 128'(ready), 128'(1));
      check_eq("rst_busy",  128'(busy),  128'(0));
      check_eq("rst_done",  128'(done),  128'(0));
      check_eq("rst_ct",    ciphertext,  128'(0));
      check_eq("rst_round", 128'(round_idx), 128'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      run_block("c1", C1_PT, C1_KEY, C1_CT, 0);

      // FIPS-197 B, also checking the state after the initial key mix
      plaintext = B_PT; key = B_KEY; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_eq("b_state0", dut.blk_q, B_S0);
      repeat (10) @(posedge clk); #1;
      check_eq("b_done", 128'(done), 128'(1));
      check_eq("b_ct",   ciphertext, B_CT);
      $display("blk b pt=%h key=%h ct=%h", B_PT, B_KEY, ciphertext);
      @(posedge clk); #1;

      // back-to-back: start held high, second block's inputs presented during RUN
      plaintext = C1_PT; key = C1_KEY; start = 1'b1;
      @(posedge clk); #1;
      plaintext = B_PT; key = B_KEY;
      repeat (10) @(posedge clk); #1;
      check_eq("b2b_done1", 128'(done), 128'(1));
      check_eq("b2b_ct1",   ciphertext, C1_CT);
      $display("blk b2b1 ct=%h", ciphertext);
      @(posedge clk); #1;
      start = 1'b0;
      check_eq("b2b_gap",  128'(done), 128'(0));
      check_eq("b2b_busy", 128'(busy), 128'(1));
      check_eq("b2b_r1",   128'(round_idx), 128'(1));
      check_eq("b2b_hold", ciphertext, C1_CT);
      repeat (10) @(posedge clk); #1;
      check_eq("b2b_done2", 128'(done), 128'(1));
      check_eq("b2b_ct2",   ciphertext, B_CT);
      $display("blk b2b2 ct=%h", ciphertext);
      @(posedge clk); #1;
      check_eq("b2b_pulse", 128'(done), 128'(0));

      // start pulsed at round 5 must not disturb the running block
      run_block("poke", C1_PT, C1_KEY, C1_CT, 5);

      // asynchronous reset during round 4
      plaintext = B_PT; key = B_KEY; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk); #1;
      check_eq("abort_r4", 128'(round_idx), 128'(4));
      #2 rst = 1'b1;
      #1;
      check_eq("abort_ct",    ciphertext, 128'(0));
      check_eq("abort_ready", 128'(ready), 128'(1));
      check_eq("abort_busy",  128'(busy),  128'(0));
      check_eq("abort_round", 128'(round_idx), 128'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (done) seen_done = 1'b1;
         @(posedge clk); #1;
      end
      check_eq("abort_nodone", 128'(seen_done), 128'(0));
      $display("blk abort ct=%h", ciphertext);
      run_block("c1_after_rst", C1_PT, C1_KEY, C1_CT, 0);

      // idle hold
      for (int i = 0; i < 50; i++) begin
         if (i % 10 == 0) begin
            check_eq("hold_ct",    ciphertext, C1_CT);
            check_eq("hold_done",  128'(done), 128'(0));
            check_eq("hold_round", 128'(round_idx), 128'(0));
         end
         @(posedge clk); #1;
      end

      // random blocks against the reference model
      for (int n = 0; n < 20; n++) begin
         pt_r  = rand128();
         key_r = rand128();
         want  = aes_ref(pt_r, key_r);
         run_block($sformatf("rnd%0d", n), pt_r, key_r, want, (n % 3 == 0) ? int'($urandom_range(1, 10)) : 0);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
